thread_scheduler: RTL



---
 rtl/thread_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/thread_scheduler.sv
// Round-robin time-slice scheduler: grants one hardware thread at a time and drains the pipeline
// on every thread change. Optional voluntary yield is enabled with `define SCHED_YIELD_EN.
module thread_scheduler #(
  parameter int unsigned NUM_TRD   = 8,
  parameter int unsigned QUANTUM   = 16,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_TRD-1:0] running,
  input  logic               stall,
`ifdef SCHED_YIELD_EN
  input  logic               yield,
`endif
  output logic [2:0]         act_trd,
  output logic               act_vld,
  output logic               trd_switch,
  output logic               flush,
  output logic [7:0]         q_left
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e     state_q, state_d;
  logic [2:0] act_trd_q, act_trd_d;
  logic       act_vld_q, act_vld_d;
  logic       trd_switch_q, trd_switch_d;
  logic       flush_q, flush_d;
  logic [7:0] q_left_q, q_left_d;
  logic [2:0] last_q, last_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;

  logic               yield_req;
  logic               pick_vld;
  logic [2:0]         pick_trd;
  logic [2:0]         cand;
  logic [NUM_TRD-1:0] others;
  logic               go_drain;
  logic               go_grant;

`ifdef SCHED_YIELD_EN
  assign yield_req = yield;
`else
  assign yield_req = 1'b0;
`endif

  // Search starts just after the last grant, so the last-granted thread is considered last.
  always_comb begin
    pick_vld = 1'b0;
    pick_trd = last_q;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_TRD; i++) begin
      cand = 3'((32'(last_q) + i) % NUM_TRD);
      if (!pick_vld && running[cand]) begin
        pick_vld = 1'b1;
        pick_trd = cand;
      end
    end
  end

  always_comb begin
    others          = running;
    others[act_trd_q] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    act_trd_d    = act_trd_q;
    act_vld_d    = act_vld_q;
    trd_switch_d = 1'b0;
    flush_d      = flush_q;
    q_left_d     = q_left_q;
    last_d       = last_q;
    drain_cnt_d  = drain_cnt_q;
    go_drain     = 1'b0;
    go_grant     = 1'b0;

    unique case (state_q)
      StIdle: begin
        act_vld_d = 1'b0;
        flush_d   = 1'b0;
        go_grant  = pick_vld;
      end
      StRun: begin
        if (!running[act_trd_q]) begin
          go_drain = 1'b1;
        end else if (!stall && (q_left_q <= 8'd1 || yield_req)) begin
          if (|others) go_drain = 1'b1;
          else         q_left_d = 8'(QUANTUM);
        end else if (!stall) begin
          q_left_d = q_left_q - 8'd1;
        end
      end
      StDrain: begin
        if (drain_cnt_q == 3'd0) begin
          flush_d = 1'b0;
          if (pick_vld) begin
            go_grant = 1'b1;
          end else begin
            state_d   = StIdle;
            act_vld_d = 1'b0;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_drain) begin
      state_d     = StDrain;
      flush_d     = 1'b1;
      act_vld_d   = 1'b0;
      q_left_d    = 8'd0;
      drain_cnt_d = 3'(DRAIN_CYC - 1);
    end

    if (go_grant) begin
      state_d      = StRun;
      act_trd_d    = pick_trd;
      last_d       = pick_trd;
      act_vld_d    = 1'b1;
      trd_switch_d = 1'b1;
      q_left_d     = 8'(QUANTUM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      act_trd_q    <= 3'd0;
      act_vld_q    <= 1'b0;
      trd_switch_q <= 1'b0;
      flush_q      <= 1'b0;
      q_left_q     <= 8'd0;
      last_q       <= 3'(NUM_TRD - 1);
      drain_cnt_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      act_trd_q    <= act_trd_d;
      act_vld_q    <= act_vld_d;
      trd_switch_q <= trd_switch_d;
      flush_q      <= flush_d;
      q_left_q     <= q_left_d;
      last_q       <= last_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign act_trd    = act_trd_q;
  assign act_vld    = act_vld_q;
  assign trd_switch = trd_switch_q;
  assign flush      = flush_q;
  assign q_left     = q_left_q;

endmodule
